// File: rtl/mips_muldiv32.sv
// mips_muldiv32: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Each op runs as one bit per cycle for WIDTH cycles on magnitudes, then a
// single FIX cycle applies the sign correction and writes HI/LO. Latency is
// fixed: every accepted op writes its result WIDTH+1 edges after acceptance.
module mips_muldiv32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 is_div;
    logic                 neg_q;      // product / quotient must be negated
    logic                 neg_r;      // remainder takes the dividend's sign
    logic                 div0;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    // MUL: {partial product high, multiplier shifting out at bit 0}
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0]   acc;

    logic                 sgn_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     a_back;

    // Operand conditioning at issue plus one iteration step of each datapath
    always_comb begin
        sgn_op    = ~op[0];
        a_neg     = sgn_op & A[WIDTH-1];
        b_neg     = sgn_op & B[WIDTH-1];
        abs_a     = a_neg ? (~A + 1'b1) : A;
        abs_b     = b_neg ? (~B + 1'b1) : B;

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift - {1'b0, mag_b};
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};

        prod_fix  = neg_q ? (~acc + 1'b1) : acc;
        quot_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
        // Re-signing |A| restores the latched A, so no raw copy is kept
        a_back    = neg_r ? (~mag_a + 1'b1) : mag_a;
    end

    // Control FSM, iteration registers and HI/LO write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div0        <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= op[1] & (B == '0);
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= op[1] ? S_DIV : S_MUL;
                    end else begin
                        if (mthi) hi <= A;
                        if (mtlo) lo <= A;
                    end
                end
                S_MUL, S_DIV: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc <= (state == S_MUL) ? mul_next : div_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (div0) begin
                            hi <= a_back;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                        done        <= 1'b1;
                        div_by_zero <= div0;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_muldiv32.sv
// tb_mips_muldiv32: scoreboard bench for the multi-cycle mult/div unit.
module tb_mips_muldiv32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cancel = 1'b0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_muldiv32 #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dbz = 1'b0;
        case (o)
            2'b00: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                end else if (o == 2'b10) begin
                    e.lo = 32'(sa / sb);
                    e.hi = 32'(sa % sb);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Issue one op, wait (bounded) for done, then pop and compare
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        bit   busy_ok;
        sb_q.push_back(model(o, a, b));
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom;
        check({tag, " busy@accept"}, 64'(busy), 64'd1);
        check({tag, " done low@accept"}, 64'({done, div_by_zero}), 64'd0);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " busy held"}, 64'(busy_ok), 64'd1);
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        e = sb_q.pop_front();
        check({tag, " hi"}, 64'(hi), 64'(e.hi));
        check({tag, " lo"}, 64'(lo), 64'(e.lo));
        check({tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
    endtask

    initial begin
        logic [31:0] lo_save;
        bit          seen_done;

        // Reset state
        #2;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset flags", 64'({busy, done, div_by_zero}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Moves to HI/LO
        A = 32'h0000_CAFE; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h0000_CAFE);
        check("mthi+mtlo lo", 64'(lo), 64'h0000_CAFE);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel idle busy", 64'(busy), 64'd0);

        // Arithmetic, back to back (each start lands in the previous done cycle)
        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7);
        run_op("divu /0", 2'b11, 32'd100, 32'd0);
        run_op("div -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0);
        run_op("mult rnd", 2'b00, 32'h9E37_79B9, 32'h7F4A_7C15);
        run_op("div rnd", 2'b10, 32'h8123_4567, 32'h0000_0F0D);
        @(posedge clk); #1;
        check("dbz cleared", 64'({done, div_by_zero}), 64'd0);

        // Preload HI, then cancel a MULTU with a stray start in the middle
        A = 32'h0000_1234; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'h0000_1234);
        lo_save = lo;
        op = 2'b01; A = 32'd5; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        op = 2'b11; A = 32'd50; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("busy before cancel", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("busy after cancel", 64'(busy), 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("no done after cancel", 64'(seen_done), 64'd0);
        check("hi kept after cancel", 64'(hi), 64'h0000_1234);
        check("lo kept after cancel", 64'(lo), 64'(lo_save));

        // start beats mtlo in the same cycle
        op = 2'b01; A = 32'h0000_0055; B = 32'd3; start = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
        check("start beats mtlo", 64'(lo), 64'(lo_save));
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel2 busy", 64'(busy), 64'd0);
        check("cancel2 lo", 64'(lo), 64'(lo_save));

        // Async reset in the middle of a DIV
        run_op("divu pre-reset", 2'b11, 32'd1000, 32'd7);
        op = 2'b10; A = 32'd12345; B = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        check("midreset busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("divu 9/3", 2'b11, 32'd9, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
